// File: rtl/seq_detect_scheduler.sv
// -----------------------------------------------------------------------------
// seq_detect_scheduler
//
// One shared "RUN_LEN consecutive 1s" Mealy detector time-multiplexed across
// NUM_CH serial requesters. A round-robin arbiter accepts at most one bit per
// cycle. Each channel keeps its own run-length context. Every detection is
// reported one cycle later with its channel ID and a saturating running total.
//
// Ports:
//   clk        in   rising-edge system clock
//   reset      in   asynchronous active-low reset
//   enable     in   1 = arbitration/detection active, 0 = no grants
//   ch_valid   in   [NUM_CH]  per-channel bit offer
//   ch_bit     in   [NUM_CH]  per-channel data bit (sampled on accept)
//   ch_clr     in   [NUM_CH]  per-channel synchronous run-context clear
//   ch_ready   out  [NUM_CH]  one-hot grant (combinational)
//   detected   out  registered one-cycle detection pulse
//   det_ch     out  [clog2(NUM_CH)] channel of the last detection
//   det_total  out  [TOT_W]   saturating detection count since reset
// -----------------------------------------------------------------------------
module seq_detect_scheduler #(
    parameter int NUM_CH  = 4,
    parameter int RUN_LEN = 3,
    parameter int TOT_W   = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [NUM_CH-1:0]         ch_valid,
    input  logic [NUM_CH-1:0]         ch_bit,
    input  logic [NUM_CH-1:0]         ch_clr,
    output logic [NUM_CH-1:0]         ch_ready,
    output logic                      detected,
    output logic [$clog2(NUM_CH)-1:0] det_ch,
    output logic [TOT_W-1:0]          det_total
);

    localparam int CH_W  = $clog2(NUM_CH);
    localparam int CNT_W = $clog2(RUN_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(RUN_LEN - 1);
    localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CH - 1);

    logic [CH_W-1:0]  ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q [NUM_CH];
    logic [CNT_W-1:0] cnt_d [NUM_CH];
    logic             detected_q, detected_d;
    logic [CH_W-1:0]  det_ch_q, det_ch_d;
    logic [TOT_W-1:0] det_total_q, det_total_d;

    logic             found;
    logic [CH_W-1:0]  gnt_idx;
    logic [CH_W-1:0]  scan_idx;
    int unsigned      scan_sum;
    logic             det_hit;

    // Round-robin search starting at ptr_q. Because ready is only raised on a
    // valid channel, "found" is also the accept strobe for this cycle.
    // NOTE: every signal driven here gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        found    = 1'b0;
        gnt_idx  = '0;
        scan_idx = '0;
        scan_sum = 0;
        ch_ready = '0;
        if (reset && enable) begin
            for (int k = 0; k < NUM_CH; k++) begin
                scan_sum = int'(ptr_q) + k;
                if (scan_sum >= NUM_CH) begin
                    scan_sum = scan_sum - NUM_CH;
                end
                scan_idx = CH_W'(scan_sum);
                if (!found && ch_valid[scan_idx]) begin
                    found   = 1'b1;
                    gnt_idx = scan_idx;
                end
            end
        end
        for (int i = 0; i < NUM_CH; i++) begin
            ch_ready[i] = found && (gnt_idx == CH_W'(i));
        end
    end

    // Context update and Mealy detection for the granted channel.
    always_comb begin
        det_hit = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_d[i] = cnt_q[i];
        end

        if (found) begin
            if (!ch_bit[gnt_idx]) begin
                cnt_d[gnt_idx] = '0;
            end else if (cnt_q[gnt_idx] == CNT_MAX) begin
                // Counter parks at its maximum so every further 1 re-detects
                // (overlapping runs). A coincident clear suppresses the hit.
                det_hit = !ch_clr[gnt_idx];
            end else begin
                cnt_d[gnt_idx] = cnt_q[gnt_idx] + 1'b1;
            end
        end

        // Clear is applied last so it overrides any accept on the same channel.
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_clr[i]) begin
                cnt_d[i] = '0;
            end
        end

        if (found) begin
            ptr_d = (gnt_idx == LAST_CH) ? '0 : gnt_idx + 1'b1;
        end else begin
            ptr_d = ptr_q;
        end

        detected_d  = det_hit;
        det_ch_d    = det_hit ? gnt_idx : det_ch_q;
        det_total_d = (det_hit && (det_total_q != '1)) ? det_total_q + 1'b1
                                                       : det_total_q;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    // NOTE: the per-channel context array is reset too; it is only a few flops
    // and a reset mid-run must discard every partial run.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q       <= '0;
            detected_q  <= 1'b0;
            det_ch_q    <= '0;
            det_total_q <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            ptr_q       <= ptr_d;
            detected_q  <= detected_d;
            det_ch_q    <= det_ch_d;
            det_total_q <= det_total_d;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign detected  = detected_q;
    assign det_ch    = det_ch_q;
    assign det_total = det_total_q;

endmodule

// File: tb/tb_seq_detect_scheduler.sv
// -----------------------------------------------------------------------------
// tb_seq_detect_scheduler
//
// Drives two instances of seq_detect_scheduler from the same stimulus: one
// with the default 8-bit total and one with a 2-bit total to exercise
// saturation. A behavioural model (unbounded run lengths, plain integer total)
// predicts every output, and a negedge process compares it each cycle.
// Directed sequences add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_seq_detect_scheduler;

    localparam int NUM_CH  = 4;
    localparam int RUN_LEN = 3;
    localparam int CH_W    = $clog2(NUM_CH);

    logic              clk;
    logic              reset;
    logic              enable;
    logic [NUM_CH-1:0] ch_valid;
    logic [NUM_CH-1:0] ch_bit;
    logic [NUM_CH-1:0] ch_clr;

    logic [NUM_CH-1:0] ch_ready,  ch_ready_s;
    logic              detected,  detected_s;
    logic [CH_W-1:0]   det_ch,    det_ch_s;
    logic [7:0]        det_total;
    logic [1:0]        det_total_s;

    int n_cmp  = 0;
    int n_fail = 0;

    seq_detect_scheduler #(.NUM_CH(NUM_CH), .RUN_LEN(RUN_LEN), .TOT_W(8)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .ch_valid(ch_valid), .ch_bit(ch_bit), .ch_clr(ch_clr),
        .ch_ready(ch_ready), .detected(detected),
        .det_ch(det_ch), .det_total(det_total)
    );

    seq_detect_scheduler #(.NUM_CH(NUM_CH), .RUN_LEN(RUN_LEN), .TOT_W(2)) dut_s (
        .clk(clk), .reset(reset), .enable(enable),
        .ch_valid(ch_valid), .ch_bit(ch_bit), .ch_clr(ch_clr),
        .ch_ready(ch_ready_s), .detected(detected_s),
        .det_ch(det_ch_s), .det_total(det_total_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int   m_ptr;
    int   m_run [NUM_CH];
    logic m_det;
    int   m_det_ch;
    int   m_total;

    function automatic int exp_grant(input int ptr, input logic [NUM_CH-1:0] v,
                                     input logic en);
        if (!en) return -1;
        for (int k = 0; k < NUM_CH; k++) begin
            if (v[(ptr + k) % NUM_CH]) return (ptr + k) % NUM_CH;
        end
        return -1;
    endfunction

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    always @(posedge clk or negedge reset) begin : model
        int   g;
        logic hit;
        if (!reset) begin
            m_ptr    <= 0;
            m_det    <= 1'b0;
            m_det_ch <= 0;
            m_total  <= 0;
            for (int i = 0; i < NUM_CH; i++) m_run[i] <= 0;
        end else begin
            g   = exp_grant(m_ptr, ch_valid, enable);
            hit = 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                if (ch_clr[i]) begin
                    m_run[i] <= 0;
                end else if (i == g) begin
                    if (ch_bit[i]) begin
                        m_run[i] <= m_run[i] + 1;
                        if (m_run[i] + 1 >= RUN_LEN) hit = 1'b1;
                    end else begin
                        m_run[i] <= 0;
                    end
                end
            end
            if (g >= 0) m_ptr <= (g + 1) % NUM_CH;
            m_det <= hit;
            if (hit) begin
                m_det_ch <= g;
                m_total  <= m_total + 1;
            end
        end
    end

    // Per-cycle comparison, away from the active edge.
    always @(negedge clk) begin : compare
        int          g;
        logic [NUM_CH-1:0] er;
        g  = exp_grant(m_ptr, ch_valid, enable);
        er = '0;
        if (reset && g >= 0) er[g] = 1'b1;
        check("ch_ready",    32'(ch_ready),    32'(er));
        check("ch_ready_s",  32'(ch_ready_s),  32'(er));
        check("detected",    32'(detected),    32'(m_det));
        check("detected_s",  32'(detected_s),  32'(m_det));
        check("det_ch",      32'(det_ch),      32'(m_det_ch));
        check("det_total",   32'(det_total),   32'(sat(m_total, 255)));
        check("det_total_s", 32'(det_total_s), 32'(sat(m_total, 3)));
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_reset();
        reset    = 1'b0;
        ch_valid = '0;
        ch_bit   = '0;
        ch_clr   = '0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Offer one bit on channel c (optionally with a coincident clear) and
    // wait, bounded, for its acceptance. Returns at accept edge + 1.
    task automatic send(input int c, input logic b, input logic clr);
        logic accepted;
        accepted    = 1'b0;
        ch_valid[c] = 1'b1;
        ch_bit[c]   = b;
        ch_clr[c]   = clr;
        for (int t = 0; t < 20; t++) begin
            #1;
            if (ch_ready[c]) accepted = 1'b1;
            @(posedge clk);
            #1;
            if (accepted) break;
        end
        check("send_accepted", 32'(accepted), 32'd1);
        ch_valid[c] = 1'b0;
        ch_bit[c]   = 1'b0;
        ch_clr[c]   = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // ---------------- directed tests ----------------
    initial begin : stim
        logic [7:0] t1_bits;
        logic [7:0] t1_det;
        logic [1:0] t6_tot_s [8];
        enable   = 1'b1;
        ch_valid = '0;
        ch_bit   = '0;
        ch_clr   = '0;
        reset    = 1'b1;
        #2;
        do_reset();
        check("reset_detected",  32'(detected),  32'd0);
        check("reset_det_ch",    32'(det_ch),    32'd0);
        check("reset_det_total", 32'(det_total), 32'd0);

        // Test 1: channel 0 bits 1,1,0,1,1,1,1,0 (index 0 first).
        t1_bits = 8'b0111_1011;
        t1_det  = 8'b0110_0000;
        for (int i = 0; i < 8; i++) begin
            send(0, t1_bits[i], 1'b0);
            check("t1_detected", 32'(detected), 32'(t1_det[i]));
            if (t1_det[i]) check("t1_det_ch", 32'(det_ch), 32'd0);
        end
        check("t1_total", 32'(det_total), 32'd2);

        // Test 2: all four channels valid for 16 cycles, ch0/ch2 send 1s.
        do_reset();
        ch_valid = 4'b1111;
        ch_bit   = 4'b0101;
        for (int k = 0; k < 16; k++) begin
            #1;
            check("t2_ready", 32'(ch_ready), 32'(1 << (k % 4)));
            @(posedge clk);
            #1;
            check("t2_detected", 32'(detected), 32'((k >= 8) && (k % 2 == 0)));
            if ((k >= 8) && (k % 2 == 0))
                check("t2_det_ch", 32'(det_ch), 32'((k % 4 == 0) ? 0 : 2));
        end
        ch_valid = '0;
        ch_bit   = '0;
        check("t2_total", 32'(det_total), 32'd4);

        // Test 3: clear coincident with the completing 1 on channel 1.
        do_reset();
        send(1, 1'b1, 1'b0);
        send(1, 1'b1, 1'b0);
        send(1, 1'b1, 1'b1);
        check("t3_clr_nodet", 32'(detected), 32'd0);
        send(1, 1'b1, 1'b0);
        check("t3_after1", 32'(detected), 32'd0);
        send(1, 1'b1, 1'b0);
        check("t3_after2", 32'(detected), 32'd0);
        send(1, 1'b1, 1'b0);
        check("t3_det", 32'(detected), 32'd1);
        check("t3_det_ch", 32'(det_ch), 32'd1);

        // Test 4: enable low freezes channel 0 mid-run.
        do_reset();
        send(0, 1'b1, 1'b0);
        send(0, 1'b1, 1'b0);
        enable      = 1'b0;
        ch_valid[0] = 1'b1;
        ch_bit[0]   = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("t4_ready_off", 32'(ch_ready), 32'd0);
            @(posedge clk);
            #1;
            check("t4_nodet", 32'(detected), 32'd0);
        end
        enable = 1'b1;
        #1;
        check("t4_ready_on", 32'(ch_ready), 32'b0001);
        @(posedge clk);
        #1;
        ch_valid[0] = 1'b0;
        ch_bit[0]   = 1'b0;
        check("t4_det", 32'(detected), 32'd1);
        check("t4_det_ch", 32'(det_ch), 32'd0);
        check("t4_total", 32'(det_total), 32'd1);

        // Test 5: async reset mid-run on channel 3 (total is 1 beforehand).
        send(3, 1'b1, 1'b0);
        send(3, 1'b1, 1'b0);
        ch_valid[3] = 1'b1;
        ch_bit[3]   = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        check("t5_rst_ready", 32'(ch_ready), 32'd0);
        check("t5_rst_det",   32'(detected), 32'd0);
        check("t5_rst_total", 32'(det_total), 32'd0);
        ch_valid = '0;
        ch_bit   = '0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        send(3, 1'b1, 1'b0);
        check("t5_run1", 32'(detected), 32'd0);
        send(3, 1'b1, 1'b0);
        check("t5_run2", 32'(detected), 32'd0);
        send(3, 1'b1, 1'b0);
        check("t5_det", 32'(detected), 32'd1);
        check("t5_det_ch", 32'(det_ch), 32'd3);
        check("t5_total", 32'(det_total), 32'd1);

        // Test 6: eight 1s on channel 0; 2-bit total saturates at 3.
        do_reset();
        t6_tot_s = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
        for (int i = 0; i < 8; i++) begin
            send(0, 1'b1, 1'b0);
            check("t6_total_s", 32'(det_total_s), 32'(t6_tot_s[i]));
            check("t6_total",   32'(det_total),   32'(i >= 2 ? i - 1 : 0));
        end

        repeat (3) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
